rgb2ycbcr_pipe: RTL

//  Pipelined RGB888 -> YCbCr (BT.601 studio range) converter for the capture/encode path,
//  the inverse of the display-side YCbCr->RGB converter. Valid/ready stream in and out.

---
 rtl/rgb2ycbcr_pipe.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/rgb2ycbcr_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rgb2ycbcr_pipe                                                  |
// | Desc   : 3-stage RGB888 -> BT.601 YCbCr converter, optional 4:2:2 packer  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rgb2ycbcr_pipe #(
  parameter int CHROMA_422 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        s_eol,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_cb
);

  typedef enum logic [1:0] {
    PK_EMPTY  = 2'd0,
    PK_FIRST  = 2'd1,
    PK_SECOND = 2'd2
  } pk_state_e;

  localparam logic signed [17:0] c_yr  =  18'sd66;
  localparam logic signed [17:0] c_yg  =  18'sd129;
  localparam logic signed [17:0] c_yb  =  18'sd25;
  localparam logic signed [17:0] c_cbr = -18'sd38;
  localparam logic signed [17:0] c_cbg = -18'sd74;
  localparam logic signed [17:0] c_cbb =  18'sd112;
  localparam logic signed [17:0] c_crr =  18'sd112;
  localparam logic signed [17:0] c_crg = -18'sd94;
  localparam logic signed [17:0] c_crb = -18'sd18;
  localparam logic signed [17:0] c_rnd =  18'sd128;

  function automatic logic [7:0] sat8(input logic signed [17:0] sum,
                                      input logic signed [17:0] off);
    logic signed [17:0] t;
    t = (sum >>> 8) + off;
    if (t < 18'sd0)
      return 8'd0;
    else if (t > 18'sd255)
      return 8'hFF;
    return t[7:0];
  endfunction

  logic               w_en;
  logic signed [17:0] w_r, w_g, w_b;
  logic signed [17:0] prod_q [9];
  logic               v1_q, sof1_q, eol1_q;
  logic signed [17:0] ysum_q, cbsum_q, crsum_q;
  logic               v2_q, sof2_q, eol2_q;
  logic [7:0]         y3_q, cb3_q, cr3_q;
  logic               v3_q, sof3_q, eol3_q;

  assign w_r = $signed({10'd0, s_data[23:16]});
  assign w_g = $signed({10'd0, s_data[15:8]});
  assign w_b = $signed({10'd0, s_data[7:0]});
  assign s_ready = w_en;

  // Single enable freezes every stage together; bubbles stay where they are.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      {v1_q, sof1_q, eol1_q} <= '0;
      {v2_q, sof2_q, eol2_q} <= '0;
      {v3_q, sof3_q, eol3_q} <= '0;
      ysum_q  <= '0;
      cbsum_q <= '0;
      crsum_q <= '0;
      y3_q    <= '0;
      cb3_q   <= '0;
      cr3_q   <= '0;
    end else if (w_en) begin
      v1_q      <= s_valid;
      sof1_q    <= s_sof;
      eol1_q    <= s_eol;
      prod_q[0] <= w_r * c_yr;
      prod_q[1] <= w_g * c_yg;
      prod_q[2] <= w_b * c_yb;
      prod_q[3] <= w_r * c_cbr;
      prod_q[4] <= w_g * c_cbg;
      prod_q[5] <= w_b * c_cbb;
      prod_q[6] <= w_r * c_crr;
      prod_q[7] <= w_g * c_crg;
      prod_q[8] <= w_b * c_crb;
      v2_q      <= v1_q;
      sof2_q    <= sof1_q;
      eol2_q    <= eol1_q;
      ysum_q    <= prod_q[0] + prod_q[1] + prod_q[2] + c_rnd;
      cbsum_q   <= prod_q[3] + prod_q[4] + prod_q[5] + c_rnd;
      crsum_q   <= prod_q[6] + prod_q[7] + prod_q[8] + c_rnd;
      v3_q      <= v2_q;
      sof3_q    <= sof2_q;
      eol3_q    <= eol2_q;
      y3_q      <= sat8(ysum_q,  18'sd16);
      cb3_q     <= sat8(cbsum_q, 18'sd128);
      cr3_q     <= sat8(crsum_q, 18'sd128);
    end
  end

  generate
    if (CHROMA_422 == 0) begin : g_444
      assign w_en    = !v3_q || m_ready;
      assign m_valid = v3_q;
      assign m_data  = {y3_q, cb3_q, cr3_q};
      assign m_sof   = sof3_q;
      assign m_eol   = eol3_q;
      assign m_cb    = 1'b0;
    end else begin : g_422
      pk_state_e  st_q, st_d;
      logic       hv_q, hv_d, hsof_q, hsof_d;
      logic [7:0] hy_q, hy_d, hcb_q, hcb_d, hcr_q, hcr_d;
      logic [7:0] ay_q, ay_d, ac_q, ac_d, by_q, by_d, bc_q, bc_d;
      logic       asof_q, asof_d, beol_q, beol_d;
      logic       w_ofree, w_take, w_load;
      logic [7:0] w_cbavg, w_cravg;

      assign w_cbavg = 8'(({1'b0, hcb_q} + {1'b0, cb3_q} + 9'd1) >> 1);
      assign w_cravg = 8'(({1'b0, hcr_q} + {1'b0, cr3_q} + 9'd1) >> 1);
      assign w_ofree = (st_q == PK_EMPTY) || ((st_q == PK_SECOND) && m_ready);
      assign w_en    = !v3_q || w_take;

      // H holds an even pixel awaiting its partner; A/B are the two output beats.
      always_comb begin
        st_d   = st_q;
        hv_d   = hv_q;
        hsof_d = hsof_q;
        hy_d   = hy_q;
        hcb_d  = hcb_q;
        hcr_d  = hcr_q;
        ay_d   = ay_q;
        ac_d   = ac_q;
        asof_d = asof_q;
        by_d   = by_q;
        bc_d   = bc_q;
        beol_d = beol_q;
        w_take = 1'b0;
        w_load = 1'b0;
        if (v3_q) begin
          if (hv_q && sof3_q) begin
            // Broken line: flush held pixel alone, new pixel waits a cycle.
            if (w_ofree) begin
              {ay_d, ac_d, asof_d} = {hy_q, hcb_q, hsof_q};
              {by_d, bc_d, beol_d} = {hy_q, hcr_q, 1'b1};
              hv_d   = 1'b0;
              w_load = 1'b1;
            end
          end else if (hv_q) begin
            if (w_ofree) begin
              {ay_d, ac_d, asof_d} = {hy_q, w_cbavg, hsof_q};
              {by_d, bc_d, beol_d} = {y3_q, w_cravg, eol3_q};
              hv_d   = 1'b0;
              w_take = 1'b1;
              w_load = 1'b1;
            end
          end else if (eol3_q) begin
            if (w_ofree) begin
              {ay_d, ac_d, asof_d} = {y3_q, cb3_q, sof3_q};
              {by_d, bc_d, beol_d} = {y3_q, cr3_q, 1'b1};
              w_take = 1'b1;
              w_load = 1'b1;
            end
          end else begin
            {hy_d, hcb_d, hcr_d, hsof_d} = {y3_q, cb3_q, cr3_q, sof3_q};
            hv_d   = 1'b1;
            w_take = 1'b1;
          end
        end
        if (w_load)
          st_d = PK_FIRST;
        else if (m_ready && (st_q == PK_FIRST))
          st_d = PK_SECOND;
        else if (m_ready && (st_q == PK_SECOND))
          st_d = PK_EMPTY;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q   <= PK_EMPTY;
          hv_q   <= 1'b0;
          hsof_q <= 1'b0;
          hy_q   <= '0;
          hcb_q  <= '0;
          hcr_q  <= '0;
          ay_q   <= '0;
          ac_q   <= '0;
          asof_q <= 1'b0;
          by_q   <= '0;
          bc_q   <= '0;
          beol_q <= 1'b0;
        end else begin
          st_q   <= st_d;
          hv_q   <= hv_d;
          hsof_q <= hsof_d;
          hy_q   <= hy_d;
          hcb_q  <= hcb_d;
          hcr_q  <= hcr_d;
          ay_q   <= ay_d;
          ac_q   <= ac_d;
          asof_q <= asof_d;
          by_q   <= by_d;
          bc_q   <= bc_d;
          beol_q <= beol_d;
        end
      end

      assign m_valid = (st_q != PK_EMPTY);
      assign m_data  = (st_q == PK_FIRST)  ? {ay_q, ac_q, 8'h00} :
                       (st_q == PK_SECOND) ? {by_q, bc_q, 8'h00} : 24'h0;
      assign m_cb    = (st_q == PK_FIRST);
      assign m_sof   = (st_q == PK_FIRST)  && asof_q;
      assign m_eol   = (st_q == PK_SECOND) && beol_q;
    end
  endgenerate

endmodule
`default_nettype wire
